// File: rtl/weight_memory_loader.sv
// Packs a valid/ready weight stream into N_DIM_ARRAY-lane words and writes them to the FC or CNN
// weight-memory port of the selected ping-pong bank. Optional running checksum: WLOAD_CHECKSUM_EN.
module weight_memory_loader #(
  parameter int          WEIGHT_DATA_WIDTH       = 8,
  parameter int          N_DIM_ARRAY             = 8,
  parameter int          WEIGHT_MEMORY_ADDR_SIZE = 16,
  parameter int          IN_WIDTH                = 32,
  parameter logic [2:0]  MODE_CNN                = 3'd1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic [2:0]                           mode_i,
  input  logic                                 bank_sel_i,
  input  logic [WEIGHT_MEMORY_ADDR_SIZE-2:0]   base_addr_i,
  input  logic [WEIGHT_MEMORY_ADDR_SIZE-2:0]   num_words_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  input  logic [IN_WIDTH-1:0]                  s_data_i,
  output logic                                 wr_en_ext_fc_w_o,
  output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0]   wr_addr_ext_fc_w_o,
  output logic [WEIGHT_DATA_WIDTH-1:0]         wr_data_ext_fc_w_o [N_DIM_ARRAY-1:0],
  output logic                                 wr_en_ext_cnn_w_o,
  output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0]   wr_addr_ext_cnn_w_o,
  output logic [WEIGHT_DATA_WIDTH-1:0]         wr_data_ext_cnn_w_o [N_DIM_ARRAY-1:0],
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [31:0]                          checksum_o
);

  localparam int WDW   = WEIGHT_DATA_WIDTH;
  localparam int AS    = WEIGHT_MEMORY_ADDR_SIZE;
  localparam int EPB   = IN_WIDTH / WDW;
  localparam int BEATS = N_DIM_ARRAY / EPB;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            is_cnn_q;
  logic            bank_q;
  logic [AS-2:0]   base_q;
  logic [AS-2:0]   num_q;
  logic [AS-2:0]   word_q;
  logic [BW-1:0]   beat_q;
  logic [WDW-1:0]  pack_q    [N_DIM_ARRAY-1:0];
  logic [WDW-1:0]  lane_new  [N_DIM_ARRAY-1:0];
  logic            wr_fc_q;
  logic            wr_cnn_q;
  logic [AS-1:0]   wr_addr_q;
  logic [WDW-1:0]  wr_data_q [N_DIM_ARRAY-1:0];

  logic handshake, last_beat, last_word, commit, accept_start;

  assign accept_start = (state_q == S_IDLE) && start_i;
  assign handshake    = (state_q == S_FILL) && s_valid_i;
  assign last_beat    = (beat_q == BW'(BEATS - 1));
  assign last_word    = (word_q == (num_q - {{(AS-2){1'b0}}, 1'b1}));
  assign commit       = handshake && last_beat;

  // Current beat overlays its EPB lanes on the held partial word; this is also the committed word.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIM_ARRAY; gi++) begin : g_lane
      assign lane_new[gi] = (beat_q == BW'(gi / EPB)) ? s_data_i[(gi % EPB)*WDW +: WDW] : pack_q[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (num_words_i != '0) ? S_FILL : S_DONE;
      S_FILL:  if (commit && last_word) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = (state_q == S_FILL);
    busy_o    = (state_q == S_FILL) || (state_q == S_FLUSH);
    done_o    = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      is_cnn_q  <= 1'b0;
      bank_q    <= 1'b0;
      base_q    <= '0;
      num_q     <= '0;
      word_q    <= '0;
      beat_q    <= '0;
      pack_q    <= '{default: '0};
      wr_fc_q   <= 1'b0;
      wr_cnn_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '{default: '0};
    end else begin
      // Write registers are a one-cycle strobe; address/data return to zero with the enable.
      wr_fc_q   <= 1'b0;
      wr_cnn_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '{default: '0};
      if (accept_start) begin
        is_cnn_q <= (mode_i == MODE_CNN);
        bank_q   <= bank_sel_i;
        base_q   <= base_addr_i;
        num_q    <= num_words_i;
        word_q   <= '0;
        beat_q   <= '0;
      end
      if (handshake) begin
        pack_q <= lane_new;
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (last_beat) begin
          word_q    <= word_q + 1'b1;
          wr_fc_q   <= !is_cnn_q;
          wr_cnn_q  <= is_cnn_q;
          wr_addr_q <= {bank_q, base_q + word_q};
          wr_data_q <= lane_new;
        end
      end
    end
  end

  assign wr_en_ext_fc_w_o    = wr_fc_q;
  assign wr_en_ext_cnn_w_o   = wr_cnn_q;
  assign wr_addr_ext_fc_w_o  = wr_fc_q  ? wr_addr_q : '0;
  assign wr_addr_ext_cnn_w_o = wr_cnn_q ? wr_addr_q : '0;

  generate
    for (gi = 0; gi < N_DIM_ARRAY; gi++) begin : g_out
      assign wr_data_ext_fc_w_o[gi]  = wr_fc_q  ? wr_data_q[gi] : '0;
      assign wr_data_ext_cnn_w_o[gi] = wr_cnn_q ? wr_data_q[gi] : '0;
    end
  endgenerate

`ifdef WLOAD_CHECKSUM_EN
  logic [31:0] checksum_q;
  logic [31:0] word_sum;

  always_comb begin
    word_sum = '0;
    for (int i = 0; i < N_DIM_ARRAY; i++) word_sum = word_sum + 32'($signed(lane_new[i]));
  end

  // Accumulated at the commit edge so the total is current during the write strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           checksum_q <= '0;
    else if (accept_start) checksum_q <= '0;
    else if (commit)       checksum_q <= checksum_q + word_sum;
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_weight_memory_loader.sv
// Directed bench for weight_memory_loader: packing, bank/address wrap, stalls, empty burst,
// mid-burst reset and checksum (WLOAD_CHECKSUM_EN dependent).
module tb_weight_memory_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mode;
  logic        bank_sel;
  logic [14:0] base_addr;
  logic [14:0] num_words;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        fc_en, cnn_en, busy, done;
  logic [15:0] fc_addr, cnn_addr;
  logic [7:0]  fc_data  [7:0];
  logic [7:0]  cnn_data [7:0];
  logic [31:0] checksum;
  logic [63:0] fc_flat, cnn_flat;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  weight_memory_loader dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .start_i             (start),
    .mode_i              (mode),
    .bank_sel_i          (bank_sel),
    .base_addr_i         (base_addr),
    .num_words_i         (num_words),
    .s_valid_i           (s_valid),
    .s_ready_o           (s_ready),
    .s_data_i            (s_data),
    .wr_en_ext_fc_w_o    (fc_en),
    .wr_addr_ext_fc_w_o  (fc_addr),
    .wr_data_ext_fc_w_o  (fc_data),
    .wr_en_ext_cnn_w_o   (cnn_en),
    .wr_addr_ext_cnn_w_o (cnn_addr),
    .wr_data_ext_cnn_w_o (cnn_data),
    .busy_o              (busy),
    .done_o              (done),
    .checksum_o          (checksum)
  );

  always_comb begin
    fc_flat  = '0;
    cnn_flat = '0;
    for (int i = 0; i < 8; i++) begin
      fc_flat[i*8 +: 8]  = fc_data[i];
      cnn_flat[i*8 +: 8] = cnn_data[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a start pulse for one edge; returns just after that edge with start low.
  task automatic do_start(input logic [2:0] m, input logic b, input logic [14:0] base, input logic [14:0] nw);
    start = 1'b1; mode = m; bank_sel = b; base_addr = base; num_words = nw; s_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  logic [63:0] exp_words [3];
  logic [31:0] beats3 [6];
  int          beat_idx, n_strobe, ready_idle, cyc;
  logic        hs_pred, done_seen;
  logic [31:0] exp_sum;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = '0; bank_sel = 1'b0; base_addr = '0; num_words = '0;
    s_valid = 1'b0; s_data = '0;
    tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_fc_en", {63'd0, fc_en}, 64'd0);
    chk("rst_cnn_en", {63'd0, cnn_en}, 64'd0);
    chk("rst_checksum", {32'd0, checksum}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // FC burst, bank 0, base 0x10, two words back-to-back
    do_start(3'd0, 1'b0, 15'h10, 15'd2);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_ready", {63'd0, s_ready}, 64'd1);
    s_valid = 1'b1; s_data = 32'h44332211;
    tick();
    s_data = 32'h88776655;
    tick();
    chk("t1_w0_en", {63'd0, fc_en}, 64'd1);
    chk("t1_w0_addr", {48'd0, fc_addr}, 64'h0010);
    chk("t1_w0_data", fc_flat, 64'h8877665544332211);
    chk("t1_w0_cnn_en", {63'd0, cnn_en}, 64'd0);
    s_data = 32'hDDCCBBAA;
    tick();
    chk("t1_gap_en", {63'd0, fc_en}, 64'd0);
    chk("t1_gap_addr", {48'd0, fc_addr}, 64'd0);
    chk("t1_gap_data", fc_flat, 64'd0);
    s_data = 32'h12345678;
    tick();
    chk("t1_w1_en", {63'd0, fc_en}, 64'd1);
    chk("t1_w1_addr", {48'd0, fc_addr}, 64'h0011);
    chk("t1_w1_data", fc_flat, 64'h12345678DDCCBBAA);
    chk("t1_flush_ready", {63'd0, s_ready}, 64'd0);
    chk("t1_flush_busy", {63'd0, busy}, 64'd1);
    chk("t1_flush_done", {63'd0, done}, 64'd0);
    s_valid = 1'b0;
    tick();
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_done_busy", {63'd0, busy}, 64'd0);
    chk("t1_done_en", {63'd0, fc_en}, 64'd0);
    tick();
    chk("t1_done_pulse", {63'd0, done}, 64'd0);

    // CNN burst, bank 1, base 0x7FFF: address wraps inside the bank
    do_start(3'd1, 1'b1, 15'h7FFF, 15'd2);
    s_valid = 1'b1; s_data = 32'h44332211;
    tick();
    s_data = 32'h88776655;
    tick();
    chk("t2_w0_cnn_en", {63'd0, cnn_en}, 64'd1);
    chk("t2_w0_addr", {48'd0, cnn_addr}, 64'hFFFF);
    chk("t2_w0_data", cnn_flat, 64'h8877665544332211);
    chk("t2_w0_fc_en", {63'd0, fc_en}, 64'd0);
    chk("t2_w0_fc_addr", {48'd0, fc_addr}, 64'd0);
    chk("t2_w0_fc_data", fc_flat, 64'd0);
    s_data = 32'hDDCCBBAA;
    tick();
    s_data = 32'h12345678;
    tick();
    chk("t2_w1_cnn_en", {63'd0, cnn_en}, 64'd1);
    chk("t2_w1_addr", {48'd0, cnn_addr}, 64'h8000);
    chk("t2_w1_data", cnn_flat, 64'h12345678DDCCBBAA);
    chk("t2_w1_fc_en", {63'd0, fc_en}, 64'd0);
    s_valid = 1'b0;
    tick();
    chk("t2_done", {63'd0, done}, 64'd1);
    tick();

    // s_valid toggling 1/0, three words at base 0x20
    beats3[0] = 32'h04030201; beats3[1] = 32'h08070605; beats3[2] = 32'h0C0B0A09;
    beats3[3] = 32'h100F0E0D; beats3[4] = 32'h14131211; beats3[5] = 32'h18171615;
    exp_words[0] = 64'h0807060504030201;
    exp_words[1] = 64'h100F0E0D0C0B0A09;
    exp_words[2] = 64'h1817161514131211;
    do_start(3'd0, 1'b0, 15'h20, 15'd3);
    beat_idx = 0; n_strobe = 0; ready_idle = 0; done_seen = 1'b0;
    for (cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      s_valid = ((cyc % 2) == 0) && (beat_idx < 6);
      s_data  = (beat_idx < 6) ? beats3[beat_idx] : 32'h0;
      hs_pred = s_valid && s_ready;
      tick();
      if (hs_pred) beat_idx++;
      if (s_ready && !busy) ready_idle++;
      if (fc_en) begin
        if (n_strobe < 3) begin
          chk("t3_data", fc_flat, exp_words[n_strobe]);
          chk("t3_addr", {48'd0, fc_addr}, 64'h0020 + 64'(n_strobe));
        end
        n_strobe++;
      end
      if (done) done_seen = 1'b1;
    end
    s_valid = 1'b0;
    chk("t3_done_seen", {63'd0, done_seen}, 64'd1);
    chk("t3_strobes", 64'(n_strobe), 64'd3);
    chk("t3_ready_idle", 64'(ready_idle), 64'd0);
    tick();
    chk("t3_idle_ready", {63'd0, s_ready}, 64'd0);

    // Empty burst: done in the cycle after the start cycle, nothing written
    do_start(3'd0, 1'b0, 15'h40, 15'd0);
    chk("t4_done", {63'd0, done}, 64'd1);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    chk("t4_ready", {63'd0, s_ready}, 64'd0);
    chk("t4_en", {62'd0, fc_en, cnn_en}, 64'd0);
    tick();
    chk("t4_done_pulse", {63'd0, done}, 64'd0);
    chk("t4_en2", {62'd0, fc_en, cnn_en}, 64'd0);

    // Reset after the first beat of word 0, then restart
    do_start(3'd0, 1'b0, 15'h30, 15'd2);
    s_valid = 1'b1; s_data = 32'h5A5A5A5A;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_ready", {63'd0, s_ready}, 64'd0);
    chk("t5_rst_en", {62'd0, fc_en, cnn_en}, 64'd0);
    chk("t5_rst_done", {63'd0, done}, 64'd0);
    s_valid = 1'b0;
    tick();
    chk("t5_rst_hold_en", {62'd0, fc_en, cnn_en}, 64'd0);
    rst_n = 1'b1;
    tick();
    do_start(3'd0, 1'b0, 15'h30, 15'd1);
    // start during the burst carries different fields and must be ignored
    start = 1'b1; base_addr = 15'h55; num_words = 15'd5; mode = 3'd1;
    s_valid = 1'b1; s_data = 32'hA3A2A1A0;
    tick();
    start = 1'b0;
    s_data = 32'hA7A6A5A4;
    tick();
    chk("t5_en", {63'd0, fc_en}, 64'd1);
    chk("t5_cnn_en", {63'd0, cnn_en}, 64'd0);
    chk("t5_addr", {48'd0, fc_addr}, 64'h0030);
    chk("t5_data", fc_flat, 64'hA7A6A5A4A3A2A1A0);
    s_valid = 1'b0;
    tick();
    chk("t5_done", {63'd0, done}, 64'd1);
    tick();

    // One CNN word of lanes {-1,2,-3,4,-5,6,-7,8}
`ifdef WLOAD_CHECKSUM_EN
    exp_sum = 32'd4;
`else
    exp_sum = 32'd0;
`endif
    do_start(3'd1, 1'b0, 15'h0, 15'd1);
    s_valid = 1'b1; s_data = 32'h04FD02FF;
    tick();
    s_data = 32'h08F906FB;
    tick();
    chk("t6_cnn_en", {63'd0, cnn_en}, 64'd1);
    chk("t6_cnn_addr", {48'd0, cnn_addr}, 64'h0000);
    chk("t6_cnn_data", cnn_flat, 64'h08F906FB04FD02FF);
    s_valid = 1'b0;
    tick();
    chk("t6_done", {63'd0, done}, 64'd1);
    chk("t6_checksum", {32'd0, checksum}, {32'd0, exp_sum});
    tick();
    tick();
    chk("t6_checksum_stable", {32'd0, checksum}, {32'd0, exp_sum});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
